// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment constants and hex decoder
// for the multiplexed seven-segment driver.
package seven_seg_pkg;

    localparam int SEG_W = 7;

    // Bit position of each segment in seg; pins are active-low
    typedef enum int {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg_bit_e;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    function automatic logic [SEG_W-1:0] hex_to_seg(
        input logic [3:0] h
    );
        logic [SEG_W-1:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// seg_pwm_timer: digit slot counter, digit index,
// brightness on-time compare and frame boundary strobe.
module seg_pwm_timer
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_TICKS = 200000,
    parameter int BRIGHT_BITS   = 2,
    localparam int IW = $clog2(NUM_DIGITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   idle,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic [IW-1:0]          idx,
    output logic                   lit,
    output logic                   frame_done
);

    localparam int CW = $clog2(REFRESH_TICKS);
    localparam int PW = CW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PHASE = PW'(REFRESH_TICKS >> BRIGHT_BITS);

    logic [CW-1:0] cnt;
    logic [PW-1:0] on_limit;
    logic          slot_end;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_done = !idle && slot_end && (idx == IDX_LAST);

    // Anode stays on for the first (brightness+1) phases of the slot
    assign on_limit = (PW'(brightness) + PW'(1)) * PHASE;
    assign lit      = !idle && ({1'b0, cnt} < on_limit);

    always_ff @(posedge clk) begin
        if (rst || idle) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: double-buffered, blinking, dimmable
// common-anode seven-segment multiplex driver.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_TICKS = 200000,
    parameter int BRIGHT_BITS   = 2,
    parameter int BLINK_TICKS   = 25000000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] num,
    input  logic                    num_load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    input  logic                    idle,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLINK_TICKS);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] num;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blink;
    } frame_t;

    frame_t          act;
    frame_t          pend;
    frame_t          incoming;
    logic            pend_valid;
    logic            commit;
    logic [IW-1:0]   idx;
    logic            lit;
    logic [BW-1:0]   blink_cnt;
    logic            blink_phase;
    logic [4*NUM_DIGITS-1:0] upper;
    logic            blank;

    seg_pwm_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_TICKS(REFRESH_TICKS),
        .BRIGHT_BITS  (BRIGHT_BITS)
    ) u_timer (
        .clk       (CLK),
        .rst       (RST),
        .idle      (idle),
        .brightness(brightness),
        .idx       (idx),
        .lit       (lit),
        .frame_done(frame_done)
    );

    assign incoming = {num, dp_mask, blink_mask};

    // Display is dark while idle, so a swap cannot tear a frame
    assign commit = frame_done || idle;

    always_ff @(posedge CLK) begin
        if (RST) begin
            act        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (num_load && commit) begin
            act        <= incoming;
            pend_valid <= 1'b0;
        end else if (num_load) begin
            pend       <= incoming;
            pend_valid <= 1'b1;
        end else if (commit && pend_valid) begin
            act        <= pend;
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!idle) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Current digit and everything above it, shifted to the bottom
    assign upper = act.num >> {idx, 2'b00};
    assign blank = (lz_blank && (idx != '0) && (upper == '0))
                || (act.blink[idx] && !blink_phase);

    always_ff @(posedge CLK) begin
        if (RST) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg <= blank ? SEG_BLANK : hex_to_seg(upper[3:0]);
            dp  <= blank | ~act.dp[idx];
        end
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Parametrised time-multiplexed driver for common-anode seven-segment displays with NUM_DIGITS digits.
- Decodes one hex nibble per digit and offers leading-zero blanking, per-digit decimal points, per-digit blinking and PWM brightness.
- New values are double-buffered and committed only at frame boundaries, so a display never shows a mix of old and new digits.
- Sits between datapath/controller logic and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_TICKS, 200000, CLK cycles per digit slot; must be a multiple of 2**BRIGHT_BITS.
- BRIGHT_BITS, 2, width of the brightness code.
- BLINK_TICKS, 25000000, CLK cycles per blink half-period.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- num  in  4*NUM_DIGITS  hex value; digit k = num[4k+3:4k], digit 0 rightmost.
- num_load  in  1  one-cycle strobe; captures num, dp_mask and blink_mask.
- dp_mask  in  NUM_DIGITS  1 = decimal point lit on that digit.
- blink_mask  in  NUM_DIGITS  1 = digit blinks.
- lz_blank  in  1  1 = suppress leading zeros (live, not buffered).
- brightness  in  BRIGHT_BITS  on-time code; 0 = dimmest, all-ones = full (live).
- idle  in  1  blank display and hold scan.
- an  out  NUM_DIGITS  anodes, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

Behaviour:
Reset (RST high at a posedge):
- an = all 1, seg = 7'h7F, dp = 1, frame_done = 0.
- Slot counter = 0, digit index = 0, blink counter = 0, blink_phase = 1 (visible).
- Active and pending buffers = 0; pending_valid = 0.
- RST has priority over idle and num_load.

Scan:
- Slot counter runs 0..REFRESH_TICKS-1.
- At REFRESH_TICKS-1 the counter wraps to 0 and the digit index advances; index NUM_DIGITS-1 wraps to 0.
- frame_done pulses in the cycle the index wraps NUM_DIGITS-1 -> 0.

Output latency:
- an, seg and dp are registered; they reflect counter/index/buffer state one cycle later.

Brightness:
- PHASE = REFRESH_TICKS >> BRIGHT_BITS.
- Current anode is low only while counter < (brightness+1)*PHASE; otherwise all anodes are 1.
- brightness is sampled every cycle.

Decode:
- 0 40, 1 79, 2 24, 3 30, 4 19, 5 12, 6 02, 7 78, 8 00, 9 10, A 08, b 03, C 46, d 21, E 06, F 0E (hex values of seg).

Blanking (seg forced to 7F, dp forced to 1, anode still driven):
- Condition (a): lz_blank=1, the digit is 0, and every more-significant digit is 0. Digit 0 is never blanked by this rule.
- Condition (b): blink_mask bit set and blink_phase = 0.

Blink:
- Counter runs 0..BLINK_TICKS-1; blink_phase toggles on wrap.
- Counter is frozen while idle.

Load handshake:
- num_load latches {num, dp_mask, blink_mask} into the pending buffer and sets pending_valid.
- On a frame boundary with pending_valid=1, pending is copied to active and pending_valid is cleared.
- num_load on the boundary cycle writes the new data straight into active and leaves pending_valid = 0.
- Multiple loads within one frame: last one wins.

Idle:
- While idle=1: an = all 1, slot counter and digit index held at 0, no frame_done.
- Loads are still accepted and committed directly to active.
- On idle deassert, scanning restarts at digit 0, counter 0.

Decomposition:
- Shared package seven_seg_pkg holds:
  - the hex-to-segment table as a constant function hex_to_seg;
  - the SEG_BLANK constant (7'h7F);
  - the segment-order definition.
- One sub-module, seg_pwm_timer, holds the slot counter, digit index, brightness compare and frame_done.
- Buffering, blanking and decode stay in the top-level module.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_TICKS=8, BRIGHT_BITS=2, BLINK_TICKS=64.

- Reset, then load num=16'h12AF, brightness=3 -> after the first frame_done, an cycles 1110, 1101, 1011, 0111, 8 cycles each. seg = 0E (F), 08 (A), 24 (2), 79 (1) respectively.
- num=16'h0050, lz_blank=1 -> digits 3 and 2 show seg=7F; digit 1 shows 12; digit 0 shows 40.
- num=16'h0000, lz_blank=1 -> only digit 0 lit, showing seg=40.
- brightness=0 -> each anode is low for exactly 2 of 8 cycles per slot. brightness=2 -> low for 6 of 8.
- Load 16'h1111 mid-frame, then 16'h2222 two cycles later -> no 1111 ever appears. At the next frame_done all digits show 24.
- Load strobed on the frame_done cycle -> the new value appears in the very next slot.
- blink_mask=4'b0001 -> digit 0 alternates seg 79/7F every 64 cycles while other digits stay steady.
- idle=1 -> an=1111 and frame_done silent. Release idle -> an=1110 on the following cycle.
- Assert RST mid-frame -> next cycle an=1111, seg=7F, pending discarded.
